ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between CPU word accesses and a host dump engine that
// streams a block of words out LSB-first as bytes, arbitrating round-robin per word.
module ram_port_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dump_start,
    input  logic [ADDR_W-1:0] dump_addr,
    input  logic [ADDR_W-1:0] dump_words,
    output logic              dump_busy,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int NBYTES = DATA_W / 8;
    localparam int BCNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_CPU_ACC    = 3'd1;
    localparam logic [2:0] S_CPU_RESP   = 3'd2;
    localparam logic [2:0] S_DUMP_RD    = 3'd3;
    localparam logic [2:0] S_DUMP_CAP   = 3'd4;
    localparam logic [2:0] S_DUMP_SHIFT = 3'd5;

    localparam logic GNT_CPU  = 1'b0;
    localparam logic GNT_DUMP = 1'b1;

    logic [2:0]        state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic              dump_pend_q, dump_pend_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BCNT_W-1:0] byte_idx_q, byte_idx_d;
    logic              accept;

    // A job is only accepted while none is pending, so a running job is never disturbed.
    assign accept = dump_start && !dump_pend_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        dump_pend_d = dump_pend_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        shift_d     = shift_q;
        byte_idx_d  = byte_idx_q;

        case (state_q)
            S_IDLE: begin
                if (cpu_req && (!dump_pend_q || last_gnt_q == GNT_DUMP)) begin
                    state_d    = S_CPU_ACC;
                    last_gnt_d = GNT_CPU;
                end else if (dump_pend_q) begin
                    state_d    = S_DUMP_RD;
                    last_gnt_d = GNT_DUMP;
                end
            end
            S_CPU_ACC:  state_d = cpu_we ? S_IDLE : S_CPU_RESP;
            S_CPU_RESP: state_d = S_IDLE;
            S_DUMP_RD:  state_d = S_DUMP_CAP;
            S_DUMP_CAP: begin
                shift_d    = ram_rdata;
                byte_idx_d = '0;
                state_d    = S_DUMP_SHIFT;
            end
            S_DUMP_SHIFT: begin
                shift_d    = shift_q >> 8;
                byte_idx_d = byte_idx_q + BCNT_W'(1);
                if (byte_idx_q == BCNT_W'(NBYTES - 1)) begin
                    // Word finished: go back to IDLE so a waiting CPU can slip in.
                    state_d     = S_IDLE;
                    cur_addr_d  = cur_addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - ADDR_W'(1);
                    if (remaining_q == '0) begin
                        dump_pend_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            dump_pend_d = 1'b1;
            cur_addr_d  = dump_addr;
            remaining_d = dump_words;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the edge.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_gnt_q  <= GNT_DUMP;
            dump_pend_q <= 1'b0;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            shift_q     <= '0;
            byte_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            dump_pend_q <= dump_pend_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            shift_q     <= shift_d;
            byte_idx_q  <= byte_idx_d;
        end
    end

    // Outputs decode from state so each is forced to zero in every other state.
    always_comb begin
        cpu_gnt    = (state_q == S_CPU_ACC);
        cpu_rvalid = (state_q == S_CPU_RESP);
        cpu_rdata  = (state_q == S_CPU_RESP) ? ram_rdata : '0;
        byte_valid = (state_q == S_DUMP_SHIFT);
        byte_out   = (state_q == S_DUMP_SHIFT) ? shift_q[7:0] : 8'h00;
        ram_we     = (state_q == S_CPU_ACC) && cpu_we;
        ram_wdata  = (state_q == S_CPU_ACC) ? cpu_wdata : '0;
        ram_addr   = '0;
        if (state_q == S_CPU_ACC) begin
            ram_addr = cpu_addr;
        end else if (state_q == S_DUMP_RD) begin
            ram_addr = cur_addr_q;
        end
    end

    // The pending flag spans exactly acceptance+1 through the final byte, which is the busy window.
    assign dump_busy = dump_pend_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a behavioural RAM, a word-level reference memory and
// byte/grant monitors, driven by directed cases followed by random transactions.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [4:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dump_start;
    logic [4:0]  dump_addr, dump_words;
    logic        dump_busy;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        ram_we;
    logic [4:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int viol     = 0;

    logic [31:0] ram_mem [32] = '{default: '0};
    logic [31:0] ref_mem [32] = '{default: '0};
    logic [7:0]  got_bytes [$];
    logic [7:0]  exp_bytes [$];
    int          order_q [$];   // 0 = CPU grant, 1 = start of a dumped word
    logic        prev_bv = 1'b0;

    ram_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dump_start(dump_start), .dump_addr(dump_addr), .dump_words(dump_words),
        .dump_busy(dump_busy), .byte_out(byte_out), .byte_valid(byte_valid),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    always @(negedge clk) begin
        if (byte_valid) begin
            got_bytes.push_back(byte_out);
            if (!prev_bv) order_q.push_back(1);
        end
        if (cpu_gnt) order_q.push_back(0);
        if ((ram_we && !cpu_gnt) || (cpu_rvalid && (byte_valid || cpu_gnt)) ||
            (byte_valid && cpu_gnt))
            viol++;
        prev_bv = byte_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [127:0] all_outputs();
        return 128'({cpu_gnt, cpu_rvalid, cpu_rdata, dump_busy, byte_out, byte_valid,
                     ram_we, ram_addr, ram_wdata});
    endfunction

    // Expected dump stream: each word from consecutive addresses modulo 32, LSB first.
    task automatic build_exp(input logic [4:0] a, input logic [4:0] w);
        exp_bytes.delete();
        for (int i = 0; i <= int'(w); i++) begin
            logic [31:0] word;
            word = ref_mem[5'((int'(a) + i) % 32)];
            for (int b = 0; b < 4; b++) exp_bytes.push_back(word[8*b +: 8]);
        end
    endtask

    task automatic compare_bytes(input string tag);
        check($sformatf("%s_len", tag), 128'(got_bytes.size()), 128'(exp_bytes.size()));
        for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++)
            check($sformatf("%s_b%0d", tag, i), 128'(got_bytes[i]), 128'(exp_bytes[i]));
    endtask

    task automatic cpu_op(input logic we, input logic [4:0] a, input logic [31:0] d,
                          output int lat);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        lat = 0;
        while (!cpu_gnt && lat < 100) begin
            tick();
            lat++;
        end
        check("cpu_gnt_seen", 128'(cpu_gnt), 128'(1));
        if (we) ref_mem[a] = d;
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0;
        if (!we) begin
            check("cpu_rvalid", 128'(cpu_rvalid), 128'(1));
            check($sformatf("cpu_rdata_a%0d", a), 128'(cpu_rdata), 128'(ref_mem[a]));
            tick();
        end else begin
            check("no_rvalid_after_write", 128'(cpu_rvalid), 128'(0));
        end
    endtask

    // Runs one dump job to completion; if poke > 0 a second dump_start is pulsed mid-job.
    task automatic dump_job(input logic [4:0] a, input logic [4:0] w, input int poke);
        int n;
        build_exp(a, w);
        got_bytes.delete();
        dump_start = 1'b1; dump_addr = a; dump_words = w;
        tick();
        dump_start = 1'b0;
        check("dump_busy_set", 128'(dump_busy), 128'(1));
        n = 0;
        while (dump_busy && n < 400) begin
            if (n == poke) begin
                dump_start = 1'b1; dump_addr = ~a; dump_words = 5'd3;
            end else begin
                dump_start = 1'b0;
            end
            tick();
            n++;
        end
        dump_start = 1'b0;
        check("dump_busy_clear", 128'(dump_busy), 128'(0));
        compare_bytes($sformatf("dump_a%0d_w%0d", a, w));
    endtask

    initial begin
        int lat;
        logic [7:0] b030 [4];
        int exp_order [4];
        b030 = '{8'h44, 8'h33, 8'h22, 8'h11};
        exp_order = '{0, 1, 0, 1};

        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dump_start = 1'b0; dump_addr = '0; dump_words = '0;
        tick(); tick();
        check("reset_outputs", all_outputs(), 128'(0));
        rst_n = 1'b1;
        tick();

        // Write then cycle-exact single-word dump: bytes on cycles 4..7 after acceptance.
        cpu_op(1'b1, 5'd3, 32'h1122_3344, lat);
        check("wr_gnt_latency", 128'(lat), 128'(1));
        dump_start = 1'b1; dump_addr = 5'd3; dump_words = 5'd0;
        tick();
        dump_start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("d030_busy_k%0d", k), 128'(dump_busy), 128'(k <= 7));
            check($sformatf("d030_bv_k%0d", k), 128'(byte_valid), 128'(k >= 4 && k <= 7));
            if (k >= 4 && k <= 7)
                check($sformatf("d030_byte_k%0d", k), 128'(byte_out), 128'(b030[k-4]));
            if (k < 8) tick();
        end

        // Read-back: grant one cycle after the request, data the cycle after that.
        cpu_op(1'b0, 5'd3, 32'h0, lat);
        check("rd_gnt_latency", 128'(lat), 128'(1));
        check("rd_ref_value", 128'(ref_mem[3]), 128'(32'h1122_3344));

        // Address wrap 31 -> 0.
        cpu_op(1'b1, 5'd31, 32'hA1B2_C3D4, lat);
        cpu_op(1'b1, 5'd0, 32'h0F1E_2D3C, lat);
        dump_job(5'd31, 5'd1, 0);

        // dump_start during a busy job is ignored.
        cpu_op(1'b1, 5'd8, 32'hDEAD_BEEF, lat);
        cpu_op(1'b1, 5'd9, 32'h0BAD_F00D, lat);
        dump_job(5'd8, 5'd1, 3);

        // Simultaneous start: CPU wins first (dump not yet pending), then strict alternation.
        cpu_op(1'b1, 5'd4, 32'hCAFE_F00D, lat);
        build_exp(5'd3, 5'd1);
        got_bytes.delete();
        order_q.delete();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd5; cpu_wdata = 32'h55AA_55AA;
        ref_mem[5] = 32'h55AA_55AA;
        dump_start = 1'b1; dump_addr = 5'd3; dump_words = 5'd1;
        tick();
        dump_start = 1'b0;
        begin
            int n;
            n = 0;
            while (dump_busy && n < 400) begin
                tick();
                n++;
            end
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        check("rr_busy_clear", 128'(dump_busy), 128'(0));
        check("rr_order_len", 128'(order_q.size()), 128'(4));
        for (int i = 0; i < 4 && i < order_q.size(); i++)
            check($sformatf("rr_order_%0d", i), 128'(order_q[i]), 128'(exp_order[i]));
        compare_bytes("rr_dump");
        cpu_op(1'b0, 5'd5, 32'h0, lat);

        // Reset during the second byte aborts the job completely.
        cpu_op(1'b1, 5'd10, 32'h8899_AABB, lat);
        dump_start = 1'b1; dump_addr = 5'd10; dump_words = 5'd2;
        tick();
        dump_start = 1'b0;
        for (int k = 2; k <= 5; k++) tick();
        check("rst_mid_bv", 128'(byte_valid), 128'(1));
        check("rst_mid_byte", 128'(byte_out), 128'(8'hAA));
        rst_n = 1'b0;
        tick();
        check("rst_mid_outputs", all_outputs(), 128'(0));
        rst_n = 1'b1;
        got_bytes.delete();
        order_q.delete();
        for (int k = 0; k < 30; k++) tick();
        check("rst_no_bytes", 128'(got_bytes.size()), 128'(0));
        check("rst_no_grants", 128'(order_q.size()), 128'(0));
        check("rst_busy_low", 128'(dump_busy), 128'(0));

        // Random traffic against the reference memory.
        for (int i = 0; i < 40; i++) begin
            logic [4:0]  ra;
            logic [31:0] rd;
            int          op;
            ra = 5'($urandom_range(0, 31));
            rd = $urandom;
            op = int'($urandom_range(0, 2));
            if (op == 0) begin
                cpu_op(1'b1, ra, rd, lat);
            end else if (op == 1) begin
                cpu_op(1'b0, ra, 32'h0, lat);
                check("rand_rd_latency", 128'(lat), 128'(1));
            end else begin
                dump_job(ra, 5'($urandom_range(0, 3)), 0);
            end
        end

        check("protocol_violations", 128'(viol), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
